// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: instruction-fetch port (read-only)
// and load/store data port, each with a req/ack handshake.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_data;
    logic          f_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  f_ack, f_data, f_err, d_ack, d_rdata, d_err
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output f_ack, f_data, f_err, d_ack, d_rdata, d_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port negedge RAM.
// Define MEMARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int MEM_DEPTH = 9,
    parameter int AW        = 16,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | waiting for a request; RAM pins hold their last address
    // ACCESS | RAM pins stable, RAM acts on the mid-cycle negedge
    // RESP   | ack pulse to the winner; new requests ignored
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

    state_t        state, state_nxt;
    logic          grant_d, grant_d_nxt;
    logic          pick_d;
    logic [AW-1:0] win_addr;
    logic          win_bad;

    logic          ram_we_nxt;
    logic [AW-1:0] ram_addr_nxt;
    logic [DW-1:0] ram_data_nxt;
    logic          f_ack_nxt, f_err_nxt, d_ack_nxt, d_err_nxt;
    logic [DW-1:0] f_data_nxt, d_rdata_nxt;

`ifdef MEMARB_RR_EN
    // last_f = 1 means fetch won the most recent grant
    logic last_f, last_f_nxt;

    assign pick_d = bus.d_req && (!bus.f_req || last_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_f <= 1'b1;
        end else begin
            last_f <= last_f_nxt;
        end
    end
`else
    assign pick_d = bus.d_req;
`endif

    assign win_addr = pick_d ? bus.d_addr : bus.f_addr;
    assign win_bad  = (win_addr >= DEPTH);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_d     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            bus.f_ack   <= 1'b0;
            bus.f_err   <= 1'b0;
            bus.f_data  <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;
        end else begin
            state       <= state_nxt;
            grant_d     <= grant_d_nxt;
            ram_we      <= ram_we_nxt;
            ram_addr    <= ram_addr_nxt;
            ram_data    <= ram_data_nxt;
            bus.f_ack   <= f_ack_nxt;
            bus.f_err   <= f_err_nxt;
            bus.f_data  <= f_data_nxt;
            bus.d_ack   <= d_ack_nxt;
            bus.d_err   <= d_err_nxt;
            bus.d_rdata <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_d_nxt  = grant_d;
        ram_we_nxt   = ram_we;
        ram_addr_nxt = ram_addr;
        ram_data_nxt = ram_data;
        f_ack_nxt    = 1'b0;
        f_err_nxt    = 1'b0;
        d_ack_nxt    = 1'b0;
        d_err_nxt    = 1'b0;
        f_data_nxt   = bus.f_data;
        d_rdata_nxt  = bus.d_rdata;
`ifdef MEMARB_RR_EN
        last_f_nxt   = last_f;
`endif

        case (state)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    grant_d_nxt = pick_d;
`ifdef MEMARB_RR_EN
                    last_f_nxt  = !pick_d;
`endif
                    if (win_bad) begin
                        // out-of-range: answer immediately, RAM pins untouched
                        state_nxt = RESP;
                        if (pick_d) begin
                            d_ack_nxt   = 1'b1;
                            d_err_nxt   = 1'b1;
                            d_rdata_nxt = '0;
                        end else begin
                            f_ack_nxt  = 1'b1;
                            f_err_nxt  = 1'b1;
                            f_data_nxt = '0;
                        end
                    end else begin
                        state_nxt    = ACCESS;
                        ram_addr_nxt = win_addr;
                        if (pick_d && bus.d_we) begin
                            ram_we_nxt   = 1'b1;
                            ram_data_nxt = bus.d_wdata;
                        end
                    end
                end
            end

            ACCESS: begin
                // RAM is read-before-write, so a store also returns the old word
                ram_we_nxt = 1'b0;
                state_nxt  = RESP;
                if (grant_d) begin
                    d_ack_nxt   = 1'b1;
                    d_rdata_nxt = ram_rdata;
                end else begin
                    f_ack_nxt  = 1'b1;
                    f_data_nxt = ram_rdata;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
